// File: rtl/cpu_core.sv
// Multicycle 16-bit-instruction CPU core: fetch over a request/response port,
// eight-register ISA, loads/stores over a dispatch/done data port.
module cpu_core #(
  parameter int              DATA_W   = 16,
  parameter int              ADDR_W   = 16,
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk_in,
  input  logic              rst_in,
  output logic [PC_W-1:0]   pm_addr,
  output logic              pm_read_request,
  input  logic [15:0]       pm_read_data,
  input  logic              pm_read_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_dispatch_read,
  output logic              mem_dispatch_write,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic              mem_done,
  output logic              halted
);

  typedef enum logic [2:0] {S_FETCH, S_FWAIT, S_EXEC, S_MWAIT, S_HALT} state_e;

  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_LD   = 4'h6;
  localparam logic [3:0] OP_ST   = 4'h7;
  localparam logic [3:0] OP_BEQZ = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_e            state_q;
  logic [PC_W-1:0]   pc_q;
  logic [15:0]       ir_q;
  logic [DATA_W-1:0] regs_q [8];
  logic              req_q;
  logic              rd_q;
  logic              wr_q;
  logic              halted_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  // Fields of the word arriving on the fetch port (used to launch LD/ST early)
  logic [3:0] f_op;
  logic [2:0] f_rd;
  logic [2:0] f_rs;
  assign f_op = pm_read_data[15:12];
  assign f_rd = pm_read_data[11:9];
  assign f_rs = pm_read_data[8:6];

  logic [3:0]        ex_op;
  logic [2:0]        ex_rd;
  logic [2:0]        ex_rs;
  logic [DATA_W-1:0] rd_val;
  logic [DATA_W-1:0] rs_val;
  logic [PC_W-1:0]   pc_inc;
  assign ex_op  = ir_q[15:12];
  assign ex_rd  = ir_q[11:9];
  assign ex_rs  = ir_q[8:6];
  assign rd_val = regs_q[ex_rd];
  assign rs_val = regs_q[ex_rs];
  assign pc_inc = pc_q + PC_W'(1);

  logic [DATA_W-1:0] wb_d;
  logic              wb_en_d;
  logic [PC_W-1:0]   pc_d;

  always_comb begin
    wb_d    = rd_val;
    wb_en_d = 1'b0;
    pc_d    = pc_inc;
    case (ex_op)
      OP_LDI: begin wb_d = DATA_W'(ir_q[7:0]); wb_en_d = 1'b1; end
      OP_ADD: begin wb_d = rd_val + rs_val;    wb_en_d = 1'b1; end
      OP_SUB: begin wb_d = rd_val - rs_val;    wb_en_d = 1'b1; end
      OP_AND: begin wb_d = rd_val & rs_val;    wb_en_d = 1'b1; end
      OP_XOR: begin wb_d = rd_val ^ rs_val;    wb_en_d = 1'b1; end
      OP_BEQZ: begin
        if (rd_val == '0) pc_d = pc_inc + PC_W'($signed(ir_q[7:0]));
      end
      OP_JMP: pc_d = PC_W'(ir_q[11:0]);
      default: ;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      req_q       <= 1'b0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      halted_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else begin
      req_q <= 1'b0;
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      case (state_q)
        // A FETCH entered from reset has no request armed yet, so it arms one first.
        S_FETCH: begin
          if (req_q) state_q <= S_FWAIT;
          else       req_q   <= 1'b1;
        end
        S_FWAIT: begin
          if (pm_read_valid) begin
            ir_q    <= pm_read_data;
            state_q <= S_EXEC;
            // Registered dispatch lands in EXEC, letting mem_done arrive one cycle later.
            if (f_op == OP_LD || f_op == OP_ST) begin
              mem_addr_q  <= ADDR_W'(regs_q[f_rs]);
              mem_wdata_q <= regs_q[f_rd];
              rd_q        <= (f_op == OP_LD);
              wr_q        <= (f_op == OP_ST);
            end
          end
        end
        S_EXEC: begin
          case (ex_op)
            OP_LD, OP_ST: state_q <= S_MWAIT;
            OP_HALT: begin
              state_q  <= S_HALT;
              halted_q <= 1'b1;
            end
            default: begin
              if (wb_en_d) regs_q[ex_rd] <= wb_d;
              pc_q    <= pc_d;
              req_q   <= 1'b1;
              state_q <= S_FETCH;
            end
          endcase
        end
        S_MWAIT: begin
          if (mem_done) begin
            if (ex_op == OP_LD) regs_q[ex_rd] <= mem_read_data;
            pc_q    <= pc_inc;
            req_q   <= 1'b1;
            state_q <= S_FETCH;
          end
        end
        S_HALT: ;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  assign pm_addr            = pc_q;
  assign pm_read_request    = req_q;
  assign mem_addr           = mem_addr_q;
  assign mem_write_data     = mem_wdata_q;
  assign mem_dispatch_read  = rd_q;
  assign mem_dispatch_write = wr_q;
  assign halted             = halted_q;

endmodule

// File: tb/tb_cpu_core.sv
// Scoreboard bench for cpu_core: ROM/data-memory responders with configurable
// latency, expected fetches and memory ops queued per program.
module tb_cpu_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] pm_addr;
  logic        pm_req;
  logic [15:0] pm_data;
  logic        pm_valid;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_rdata;
  logic        mem_done;
  logic        halted;

  logic        w_rst;
  logic [11:0] w_pm_addr;
  logic        w_req;
  logic [15:0] w_pm_data;
  logic        w_valid;
  logic [15:0] w_mem_addr;
  logic [15:0] w_mem_wdata;
  logic        w_mem_rd;
  logic        w_mem_wr;
  logic [15:0] w_mem_rdata;
  logic        w_mem_done;
  logic        w_halted;

  cpu_core dut (
    .clk_in(clk), .rst_in(rst),
    .pm_addr(pm_addr), .pm_read_request(pm_req),
    .pm_read_data(pm_data), .pm_read_valid(pm_valid),
    .mem_addr(mem_addr), .mem_write_data(mem_wdata),
    .mem_dispatch_read(mem_rd), .mem_dispatch_write(mem_wr),
    .mem_read_data(mem_rdata), .mem_done(mem_done),
    .halted(halted)
  );

  cpu_core #(.PC_W(12), .RESET_PC(12'hFFF)) dut_w (
    .clk_in(clk), .rst_in(w_rst),
    .pm_addr(w_pm_addr), .pm_read_request(w_req),
    .pm_read_data(w_pm_data), .pm_read_valid(w_valid),
    .mem_addr(w_mem_addr), .mem_write_data(w_mem_wdata),
    .mem_dispatch_read(w_mem_rd), .mem_dispatch_write(w_mem_wr),
    .mem_read_data(w_mem_rdata), .mem_done(w_mem_done),
    .halted(w_halted)
  );

  typedef struct { logic [15:0] pc; int delta; } fetch_t;
  typedef struct { logic wr; logic [15:0] addr; logic [15:0] data; } memop_t;

  fetch_t exp_f[$];
  memop_t exp_m[$];
  int checks = 0;
  int errors = 0;
  int rom_lat = 1;
  int mem_lat = 1;
  logic [15:0] rom  [0:1023];
  logic [15:0] dmem [0:255];

  function automatic logic [15:0] i_ri(input logic [3:0] op, input logic [2:0] rd, input logic [7:0] imm);
    return {op, rd, 1'b0, imm};
  endfunction

  function automatic logic [15:0] i_rr(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs);
    return {op, rd, rs, 6'b0};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) rom[i] = 16'hF000;
    for (int i = 0; i < 256; i++) dmem[i] = 16'h0000;
    exp_f.delete();
    exp_m.delete();
  endtask

  task automatic push_fetch(input logic [15:0] pc, input int delta);
    fetch_t f;
    f.pc = pc;
    f.delta = delta;
    exp_f.push_back(f);
  endtask

  task automatic push_mem(input logic wr, input logic [15:0] addr, input logic [15:0] data);
    memop_t m;
    m.wr = wr;
    m.addr = addr;
    m.data = data;
    exp_m.push_back(m);
  endtask

  // Straight-line program: fetch i follows fetch i-1 by that instruction's cost.
  task automatic push_linear(input int n);
    for (int i = 0; i < n; i++) begin
      if (i == 0) push_fetch(16'(i), -1);
      else if (rom[i-1][15:12] == 4'h6 || rom[i-1][15:12] == 4'h7)
        push_fetch(16'(i), 2 + rom_lat + mem_lat);
      else
        push_fetch(16'(i), 2 + rom_lat);
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    pm_valid = 1'b0;
    mem_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Services fetches and memory ops each cycle, comparing against the queues.
  task automatic run_prog(input int budget, input int stop_disp);
    int cyc = 0;
    int last_f = -1;
    int f_cnt = 0;
    int m_cnt = 0;
    int n_disp = 0;
    bit done = 0;
    logic [9:0]  f_addr = '0;
    logic [15:0] m_addr = '0;
    logic [15:0] m_wdata = '0;
    logic        m_wr = 1'b0;
    fetch_t ef;
    memop_t em;
    while (!done) begin
      @(posedge clk);
      #1;
      cyc++;
      pm_valid = 1'b0;
      mem_done = 1'b0;
      if (f_cnt > 0) begin
        f_cnt--;
        if (f_cnt == 0) begin
          pm_valid = 1'b1;
          pm_data  = rom[f_addr];
        end
      end
      if (m_cnt > 0) begin
        checks++;
        if (mem_addr !== m_addr || mem_wdata !== m_wdata || mem_rd !== 1'b0 || mem_wr !== 1'b0) begin
          errors++;
          $display("FAIL mem_hold: addr=%h data=%h rd=%b wr=%b, required addr=%h data=%h rd=0 wr=0",
                   mem_addr, mem_wdata, mem_rd, mem_wr, m_addr, m_wdata);
        end
        m_cnt--;
        if (m_cnt == 0) begin
          mem_done = 1'b1;
          if (m_wr) dmem[m_addr[7:0]] = m_wdata;
          else mem_rdata = dmem[m_addr[7:0]];
        end
      end else if (mem_rd || mem_wr) begin
        n_disp++;
        checks++;
        $display("mem %s addr=%h data=%h", mem_wr ? "ST" : "LD", mem_addr, mem_wdata);
        if (exp_m.size() == 0) begin
          errors++;
          $display("FAIL mem_extra: rd=%b wr=%b addr=%h, required no dispatch", mem_rd, mem_wr, mem_addr);
        end else begin
          em = exp_m.pop_front();
          if (mem_wr !== em.wr || mem_rd !== !em.wr || mem_addr !== em.addr ||
              (em.wr && mem_wdata !== em.data)) begin
            errors++;
            $display("FAIL mem_op: wr=%b rd=%b addr=%h data=%h, required wr=%b addr=%h data=%h",
                     mem_wr, mem_rd, mem_addr, mem_wdata, em.wr, em.addr, em.data);
          end
        end
        m_addr  = mem_addr;
        m_wdata = mem_wdata;
        m_wr    = mem_wr;
        m_cnt   = mem_lat;
        if (n_disp == stop_disp) done = 1;
      end
      if (pm_req) begin
        checks++;
        $display("fetch pc=%h cycle=%0d", pm_addr, cyc);
        if (exp_f.size() == 0) begin
          errors++;
          $display("FAIL fetch_extra: pc=%h, required no fetch", pm_addr);
        end else begin
          ef = exp_f.pop_front();
          if (pm_addr !== ef.pc || (ef.delta >= 0 && cyc - last_f != ef.delta)) begin
            errors++;
            $display("FAIL fetch: pc=%h gap=%0d, required pc=%h gap=%0d",
                     pm_addr, cyc - last_f, ef.pc, ef.delta);
          end
        end
        last_f = cyc;
        f_addr = pm_addr[9:0];
        f_cnt  = rom_lat;
      end
      if (halted && !done) begin
        done = 1;
        for (int k = 0; k < 4; k++) begin
          @(posedge clk);
          #1;
          pm_valid = 1'b0;
          mem_done = 1'b0;
          checks++;
          if (pm_req !== 1'b0 || mem_rd !== 1'b0 || mem_wr !== 1'b0 || halted !== 1'b1) begin
            errors++;
            $display("FAIL halt_idle: req=%b rd=%b wr=%b halted=%b, required 0 0 0 1",
                     pm_req, mem_rd, mem_wr, halted);
          end
        end
        checks++;
        if (exp_f.size() != 0 || exp_m.size() != 0) begin
          errors++;
          $display("FAIL queue_left: fetches=%0d memops=%0d, required 0 0", exp_f.size(), exp_m.size());
        end
      end
      if (!done && cyc >= budget) begin
        checks++;
        errors++;
        $display("FAIL timeout: %0d cycles without halt, required halt", cyc);
        done = 1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    w_rst = 1'b1;
    pm_valid = 1'b1;
    mem_done = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (pm_addr !== 16'h0000 || pm_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_fetch: addr=%h req=%b, required 0000 0", pm_addr, pm_req);
    end
    checks++;
    if (mem_rd !== 1'b0 || mem_wr !== 1'b0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: rd=%b wr=%b halted=%b, required 0 0 0", mem_rd, mem_wr, halted);
    end
    checks++;
    if (mem_addr !== 16'h0000 || mem_wdata !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mem: addr=%h data=%h, required 0000 0000", mem_addr, mem_wdata);
    end
    checks++;
    if (w_pm_addr !== 12'hFFF || w_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_pc_w: addr=%h req=%b, required fff 0", w_pm_addr, w_req);
    end
    pm_valid = 1'b0;
    mem_done = 1'b0;
  endtask

  task automatic test_program();
    clear_mem();
    rom_lat = 1;
    mem_lat = 1;
    rom[0] = i_ri(4'h1, 3'd1, 8'd5);
    rom[1] = i_ri(4'h1, 3'd2, 8'd3);
    rom[2] = i_rr(4'h2, 3'd1, 3'd2);
    rom[3] = i_rr(4'h7, 3'd1, 3'd0);
    rom[4] = 16'hF000;
    push_linear(5);
    push_mem(1'b1, 16'h0000, 16'h0008);
    reset_dut();
    run_prog(100, 0);
  endtask

  task automatic test_alu_ops();
    clear_mem();
    rom_lat = 1;
    mem_lat = 1;
    rom[0]  = i_ri(4'h1, 3'd1, 8'h00);
    rom[1]  = i_ri(4'h1, 3'd2, 8'h01);
    rom[2]  = i_rr(4'h3, 3'd1, 3'd2);
    rom[3]  = i_rr(4'h7, 3'd1, 3'd0);
    rom[4]  = i_ri(4'h1, 3'd3, 8'h5A);
    rom[5]  = i_ri(4'h1, 3'd4, 8'h0F);
    rom[6]  = i_rr(4'h4, 3'd3, 3'd4);
    rom[7]  = i_ri(4'h1, 3'd5, 8'h3C);
    rom[8]  = i_rr(4'h5, 3'd5, 3'd4);
    rom[9]  = i_ri(4'h1, 3'd6, 8'h01);
    rom[10] = i_rr(4'h7, 3'd3, 3'd6);
    rom[11] = i_ri(4'h1, 3'd6, 8'h02);
    rom[12] = i_rr(4'h7, 3'd5, 3'd6);
    rom[13] = 16'hB123;
    rom[14] = 16'hF000;
    push_linear(15);
    push_mem(1'b1, 16'h0000, 16'hFFFF);
    push_mem(1'b1, 16'h0001, 16'h000A);
    push_mem(1'b1, 16'h0002, 16'h0033);
    reset_dut();
    run_prog(200, 0);
  endtask

  task automatic test_mem_slow();
    clear_mem();
    rom_lat = 2;
    mem_lat = 5;
    rom[0] = i_ri(4'h1, 3'd3, 8'hA7);
    rom[1] = i_ri(4'h1, 3'd4, 8'h20);
    rom[2] = i_rr(4'h7, 3'd3, 3'd4);
    rom[3] = i_rr(4'h6, 3'd5, 3'd4);
    rom[4] = i_ri(4'h1, 3'd6, 8'h21);
    rom[5] = i_rr(4'h7, 3'd5, 3'd6);
    rom[6] = 16'hF000;
    push_linear(7);
    push_mem(1'b1, 16'h0020, 16'h00A7);
    push_mem(1'b0, 16'h0020, 16'h0000);
    push_mem(1'b1, 16'h0021, 16'h00A7);
    reset_dut();
    run_prog(200, 0);
    rom_lat = 1;
    mem_lat = 1;
  endtask

  task automatic test_branch();
    clear_mem();
    rom[0]      = {4'h9, 12'h00A};
    rom[9]      = i_ri(4'h1, 3'd0, 8'h01);
    rom[10]     = i_ri(4'h8, 3'd0, 8'hFE);
    rom[11]     = {4'h9, 12'h123};
    rom[12'h123] = i_rr(4'h7, 3'd0, 3'd0);
    rom[12'h124] = 16'hF000;
    push_fetch(16'h0000, -1);
    push_fetch(16'h000A, 3);
    push_fetch(16'h0009, 3);
    push_fetch(16'h000A, 3);
    push_fetch(16'h000B, 3);
    push_fetch(16'h0123, 3);
    push_fetch(16'h0124, 4);
    push_mem(1'b1, 16'h0001, 16'h0001);
    reset_dut();
    run_prog(200, 0);
  endtask

  task automatic test_pc_wrap();
    logic [11:0] w_exp[$];
    logic [15:0] w_ins[$];
    bit pend = 0;
    w_exp.push_back(12'hFFF);
    w_exp.push_back(12'h000);
    w_ins.push_back(16'h0000);
    w_ins.push_back(16'hF000);
    w_valid = 1'b0;
    w_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    w_rst = 1'b0;
    for (int c = 0; c < 40 && !w_halted; c++) begin
      @(posedge clk);
      #1;
      w_valid = 1'b0;
      if (pend) begin
        pend = 0;
        w_valid = 1'b1;
        w_pm_data = w_ins.pop_front();
      end
      if (w_req) begin
        checks++;
        $display("fetch_w pc=%h", w_pm_addr);
        if (w_exp.size() == 0) begin
          errors++;
          $display("FAIL wrap_extra: pc=%h, required no fetch", w_pm_addr);
        end else begin
          logic [11:0] e;
          e = w_exp.pop_front();
          if (w_pm_addr !== e) begin
            errors++;
            $display("FAIL wrap_pc: pc=%h, required %h", w_pm_addr, e);
          end
        end
        pend = (w_ins.size() != 0);
      end
    end
    checks++;
    if (w_halted !== 1'b1 || w_exp.size() != 0) begin
      errors++;
      $display("FAIL wrap_halt: halted=%b left=%0d, required 1 0", w_halted, w_exp.size());
    end
  endtask

  task automatic test_reset_mwait();
    clear_mem();
    rom_lat = 1;
    mem_lat = 6;
    rom[0] = i_rr(4'h7, 3'd1, 3'd2);
    rom[1] = i_ri(4'h1, 3'd1, 8'h09);
    rom[2] = i_ri(4'h1, 3'd2, 8'h04);
    rom[3] = i_rr(4'h7, 3'd1, 3'd2);
    rom[4] = 16'hF000;
    push_linear(5);
    push_mem(1'b1, 16'h0000, 16'h0000);
    push_mem(1'b1, 16'h0004, 16'h0009);
    reset_dut();
    run_prog(100, 2);
    exp_f.delete();
    exp_m.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (pm_addr !== 16'h0000 || pm_req !== 1'b0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL mwait_reset_fetch: addr=%h req=%b halted=%b, required 0000 0 0", pm_addr, pm_req, halted);
    end
    checks++;
    if (mem_addr !== 16'h0000 || mem_wdata !== 16'h0000 || mem_rd !== 1'b0 || mem_wr !== 1'b0) begin
      errors++;
      $display("FAIL mwait_reset_mem: addr=%h data=%h rd=%b wr=%b, required 0000 0000 0 0",
               mem_addr, mem_wdata, mem_rd, mem_wr);
    end
    push_linear(5);
    push_mem(1'b1, 16'h0000, 16'h0000);
    push_mem(1'b1, 16'h0004, 16'h0009);
    rst = 1'b0;
    mem_done = 1'b1;
    run_prog(200, 0);
    mem_lat = 1;
  endtask

  initial begin
    rst = 1'b1;
    w_rst = 1'b1;
    pm_data = '0;
    pm_valid = 1'b0;
    mem_rdata = '0;
    mem_done = 1'b0;
    w_pm_data = '0;
    w_valid = 1'b0;
    w_mem_rdata = '0;
    w_mem_done = 1'b0;
    test_reset();
    test_program();
    test_alu_ops();
    test_mem_slow();
    test_branch();
    test_pc_wrap();
    test_reset_mwait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
